gray_ptr_sync_decode: RTL and testbench
=======================================

// Module: gray_ptr_sync_decode
// PURPOSE
//  Receive-side pointer crossing for the async FIFO: brings a Gray-coded
//  pointer from a foreign clock domain into clk_i through a multi-flop
//  synchronizer, then decodes it to binary for full/empty compare logic.
//  Combines the 2FF synchronizer and Gray-to-binary converter in one block.
//  One instance per crossing direction (wr_ptr into read domain, rd_ptr into write domain).
// PARAMETERS
//  DATA_WIDTH   2  pointer width in bits (FIFO BUFFER_DEPTH_POWER); >=1
//  SYNC_STAGES  2  synchronizer flop stages; >=2
// PORTS
//  clk_i        in   1           destination-domain clock; all flops on rising edge
//  rst_i        in   1           asynchronous, active-high reset
//  data_i       in   DATA_WIDTH  Gray-coded pointer from the source domain
//                                (asynchronous to clk_i; <=1 bit changes per step)
//  data_sync_o  out  DATA_WIDTH  synchronized Gray value (last sync stage)
//  bin_o        out  DATA_WIDTH  binary decode of data_sync_o (combinational)
//  change_o     out  1           1-cycle pulse: data_sync_o differs from previous cycle
// BEHAVIOUR
//  - Reset: rst_i high asynchronously clears every sync stage and the
//    change-detect register. data_sync_o=0, bin_o=0, change_o=0 while
//    rst_i is high and until the first post-release edge shows a change.
//  - Reset mid-operation clears all state immediately without waiting for clk_i.
//  - Sync chain: stage[0]<=data_i; stage[k]<=stage[k-1]; data_sync_o=stage[SYNC_STAGES-1].
//    Only stage[0] samples data_i. No logic, gating or enable between stages.
//  - Latency: a stable change on data_i appears on data_sync_o after exactly
//    SYNC_STAGES rising edges of clk_i (2 by default).
//  - Gray->binary: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i] for i=W-2..0.
//    Purely combinational from data_sync_o, same-cycle.
//    No register on bin_o.
//  - change_o: register prev<=data_sync_o each cycle; change_o=(data_sync_o!=prev).
//    Combinational compare of registered values; prev resets to 0.
//  - data_i is not checked. A multi-bit change, which the source must not
//    produce, propagates unaltered and no error is flagged.
//  - Wrap-around needs no special handling: Gray max->0 is a single-bit change.
//    For W=2, 10->00 decodes to bin 3->0.
//  - DATA_WIDTH=1: bin_o=data_sync_o.
// TESTING
//  1 Reset: rst_i=1 with data_i=2'b11 -> data_sync_o=0, bin_o=0, change_o=0.
//    Release rst_i, hold data_i=11 -> data_sync_o=11 after 2nd edge, bin_o=2'b10.
//  2 Decode table W=2: feed Gray 00,01,11,10 each held >=3 cycles ->
//    bin_o=0,1,2,3; change_o pulses once per step, exactly 1 cycle wide.
//  3 Latency: toggle data_i 00->01 just after edge N -> data_sync_o=01 at
//    edge N+2 (not N+1); with SYNC_STAGES=3 -> at edge N+3.
//  4 Wrap W=2: step 10->00 -> bin_o 3->0, single change_o pulse.
//    W=3: Gray 110 -> bin 100, Gray 100 -> bin 111.
//  5 Async reset mid-run: data_sync_o=10, assert rst_i between clock edges ->
//    outputs clear to 0 before the next edge. Release -> re-acquire after 2 edges.
//  6 Full sweep W=4: increment binary count, drive bin^(bin>>1) every 3
//    cycles over 2 wraps -> bin_o tracks the count with 2-cycle lag.

Source files
------------

// File: rtl/gray_ptr_sync_decode.sv
// Receive-side Gray pointer crossing: multi-flop synchronizer into clk_i,
// same-cycle Gray-to-binary decode, and a one-cycle change pulse.
module gray_ptr_sync_decode #(
  parameter int DATA_WIDTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_sync_o,
  output logic [DATA_WIDTH-1:0] bin_o,
  output logic                  change_o
);

  logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev;

  function automatic logic [DATA_WIDTH-1:0] gray_to_bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pure flop chain: no logic between stages so each stage can settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        stage[k] <= '0;
      end
      prev <= '0;
    end else begin
      stage[0] <= data_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign data_sync_o = stage[SYNC_STAGES-1];
  assign bin_o       = gray_to_bin(data_sync_o);
  assign change_o    = (data_sync_o != prev);

endmodule

// File: tb/tb_gray_ptr_sync_decode.sv
// Directed bench for gray_ptr_sync_decode: reset, W=2 decode/latency/wrap,
// W=3 with three sync stages, and a W=4 full Gray sweep.
module tb_gray_ptr_sync_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] d2;
  logic [2:0] d3;
  logic [3:0] d4;
  logic [1:0] sync2, bin2;
  logic [2:0] sync3, bin3;
  logic [3:0] sync4, bin4;
  logic       chg2, chg3, chg4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gray_ptr_sync_decode #(.DATA_WIDTH(2), .SYNC_STAGES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(d2),
    .data_sync_o(sync2), .bin_o(bin2), .change_o(chg2)
  );

  gray_ptr_sync_decode #(.DATA_WIDTH(3), .SYNC_STAGES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .data_i(d3),
    .data_sync_o(sync3), .bin_o(bin3), .change_o(chg3)
  );

  gray_ptr_sync_decode #(.DATA_WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(d4),
    .data_sync_o(sync4), .bin_o(bin4), .change_o(chg4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one Gray step on the W=2 instance and check latency, decode and pulse.
  task automatic step2(input logic [1:0] old_g, input logic [1:0] new_g, input logic [1:0] exp_bin);
    d2 = new_g;
    tick();
    check("w2_lat_hold", 32'(sync2), 32'(old_g));
    check("w2_chg_early", 32'(chg2), 32'd0);
    tick();
    check("w2_sync", 32'(sync2), 32'(new_g));
    check("w2_bin", 32'(bin2), 32'(exp_bin));
    check("w2_chg_pulse", 32'(chg2), 32'd1);
    tick();
    check("w2_chg_clear", 32'(chg2), 32'd0);
    check("w2_bin_hold", 32'(bin2), 32'(exp_bin));
  endtask

  // W=3 step with three sync stages: new value lands on the third edge.
  task automatic step3(input logic [2:0] old_g, input logic [2:0] new_g, input logic [2:0] exp_bin);
    d3 = new_g;
    tick();
    check("w3_lat_e1", 32'(sync3), 32'(old_g));
    tick();
    check("w3_lat_e2", 32'(sync3), 32'(old_g));
    tick();
    check("w3_sync", 32'(sync3), 32'(new_g));
    check("w3_bin", 32'(bin3), 32'(exp_bin));
    check("w3_chg", 32'(chg3), 32'd1);
    tick();
    check("w3_chg_clear", 32'(chg3), 32'd0);
  endtask

  initial begin
    logic [3:0] g4;
    rst = 1'b1;
    d2  = 2'b11;
    d3  = 3'b000;
    d4  = 4'b0000;
    tick();
    tick();
    check("rst_sync", 32'(sync2), 32'd0);
    check("rst_bin", 32'(bin2), 32'd0);
    check("rst_chg", 32'(chg2), 32'd0);

    // Release with data held at 11: visible after the second edge.
    rst = 1'b0;
    tick();
    check("rel_e1_sync", 32'(sync2), 32'd0);
    tick();
    check("rel_e2_sync", 32'(sync2), 32'b11);
    check("rel_e2_bin", 32'(bin2), 32'b10);
    check("rel_e2_chg", 32'(chg2), 32'd1);
    tick();
    check("rel_chg_clear", 32'(chg2), 32'd0);

    // Walk the W=2 Gray cycle, including the 10->00 wrap.
    step2(2'b11, 2'b10, 2'd3);
    step2(2'b10, 2'b00, 2'd0);
    step2(2'b00, 2'b01, 2'd1);
    step2(2'b01, 2'b11, 2'd2);
    step2(2'b11, 2'b10, 2'd3);
    step2(2'b10, 2'b00, 2'd0);
    step2(2'b00, 2'b10, 2'd3);

    // Async reset between edges clears outputs before the next edge.
    #3;
    rst = 1'b1;
    #1;
    check("arst_sync", 32'(sync2), 32'd0);
    check("arst_bin", 32'(bin2), 32'd0);
    check("arst_chg", 32'(chg2), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    check("reacq_e1", 32'(sync2), 32'd0);
    tick();
    check("reacq_e2_sync", 32'(sync2), 32'b10);
    check("reacq_e2_bin", 32'(bin2), 32'd3);

    // W=3, three stages: full Gray walk including 110->100 and 100->111.
    step3(3'b000, 3'b001, 3'b001);
    step3(3'b001, 3'b011, 3'b010);
    step3(3'b011, 3'b010, 3'b011);
    step3(3'b010, 3'b110, 3'b100);
    step3(3'b110, 3'b111, 3'b101);
    step3(3'b111, 3'b101, 3'b110);
    step3(3'b101, 3'b100, 3'b111);
    step3(3'b100, 3'b000, 3'b000);

    // W=4 sweep over two wraps, new count every 3 cycles, 2-cycle lag.
    for (int n = 1; n <= 32; n++) begin
      logic [3:0] cnt;
      cnt = 4'(n);
      g4  = cnt ^ (cnt >> 1);
      d4  = g4;
      tick();
      tick();
      check("w4_sweep_bin", 32'(bin4), 32'(cnt));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
